demux_stream: RTL and testbench
===============================

# demux_stream

Parametrised, registered 1-to-N stream demultiplexer: the next generation of the combinational 1-to-7 demux. It routes a WIDTH-bit data beat, selected by `in_sel`, to one of NUM_CH output channels, or to all channels in broadcast mode. Each channel has its own valid/ready handshake and a one-entry output register. It sits between a single producer and NUM_CH independent consumers. Beats with out-of-range selects are dropped and counted.

## Interface
- WIDTH, 8, data width in bits (≥1)
- NUM_CH, 7, number of output channels (2..2^SEL_W)
- SEL_W, 3, select width
- CNT_W, 8, drop-counter width
- clk  input  1  single clock, rising edge
- rst  input  1  reset, asynchronous and active-high
- in_valid  input  1  producer beat valid
- in_ready  output  1  block accepts beat this cycle
- in_data  input  WIDTH  beat payload
- in_sel  input  SEL_W  target channel index
- in_bcast  input  1  1 = deliver beat to all channels; in_sel ignored
- out_valid  output  NUM_CH  per-channel valid, bit i = channel i
- out_ready  input  NUM_CH  per-channel consumer ready
- out_data  output  NUM_CH*WIDTH  channel i at bits [i*WIDTH +: WIDTH]
- drop_cnt  output  CNT_W  count of dropped (out-of-range) beats, saturating
- busy  output  1  OR of out_valid

## Operation
- Each channel i has one slot register: full flag (drives out_valid[i]) and data (drives out_data slice).
- Slot i can load when `!full[i] || out_ready[i]`. This is free[i].
- Unicast, in_sel < NUM_CH: in_ready = free[in_sel]. On accept, slot in_sel loads in_data and full = 1.
- Unicast, in_sel ≥ NUM_CH: in_ready = 1. An accepted beat is discarded and drop_cnt increments. drop_cnt saturates at 2^CNT_W−1 and does not wrap.
- Broadcast: in_ready = AND of all free[i]. On accept, every slot loads in_data and full = 1. There are no partial deliveries.
- in_ready depends combinationally on in_sel, in_bcast and out_ready. It never depends on in_valid.
- Drain: when full[i] && out_ready[i] and no new load occurs, full[i] clears.
- Simultaneous drain and load on the same slot: new data is written and full stays 1, giving a back-to-back beat every cycle.
- out_data[i] holds its last value while !full[i]. Consumers must ignore it.
- Channels are independent. A stalled channel blocks only beats addressed to it and broadcasts.
- A beat held by the producer (in_valid=1, in_ready=0) must keep in_data, in_sel and in_bcast stable. The bench checks this; the block does not.

## Timing
- Latency: a beat accepted at edge k appears at out_valid/out_data after edge k. This is 1 cycle.
- Throughput: 1 beat/cycle per channel when out_ready is held high.
- Reset (async assert, sync release on clk): out_valid = 0, out_data = 0, drop_cnt = 0, busy = 0. in_ready then follows the rules above (all slots free).
- Reset mid-operation: held beats are lost and no out_valid pulse is emitted after reset deassert.
- No combinational path from in_valid to any output. The out_ready → in_ready path is permitted.

## Structure
- Package demux_pkg: default WIDTH/NUM_CH/SEL_W/CNT_W constants and a saturating-increment function for drop_cnt.
- Sub-module demux_slot (WIDTH): one-entry register with load, data_in, ready_in, outputs valid, data and free. Top instantiates it NUM_CH times in a generate loop.
- Top holds select decode, broadcast AND-reduction, in_ready mux and the drop counter.

## Test plan
- Reset then sweep: for sel 0..6, send data 8'hA0+sel with all out_ready=1 → each beat appears only on channel sel, 1 cycle later, with out_valid one-hot.
- Backpressure: out_ready[3]=0, send two beats to sel 3 → first is held and in_ready=0 for the second. Raise out_ready[3] → second delivered next cycle with no loss or duplication.
- Broadcast: in_bcast=1, data 8'h5A, out_ready[6]=0 with slot 6 full → in_ready=0. Release out_ready[6] → all 7 channels show 8'h5A together.
- Out-of-range: CNT_W=2, send sel=7 five times → in_ready=1, no out_valid, drop_cnt = 1, 2, 3, 3, 3.
- Streaming: 20 back-to-back beats to sel 1 with out_ready[1]=1 → 20 consecutive out_valid cycles, in-order data.
- Reset mid-stream: assert rst while channels 0 and 2 are full → out_valid and out_data clear immediately (async). After release, drop_cnt=0 and no stale beats appear.

Source files
------------

// File: rtl/demux_pkg.sv
`default_nettype none
// ============================================================================
// Module   : demux_pkg
// Brief    : Shared defaults, route classification and drop-counter helper
//            for the registered 1-to-N stream demultiplexer.
// Revision : 1.0 - initial release
// ============================================================================
package demux_pkg;

    localparam int c_DEFAULT_WIDTH  = 8;
    localparam int c_DEFAULT_NUM_CH = 7;
    localparam int c_DEFAULT_SEL_W  = 3;
    localparam int c_DEFAULT_CNT_W  = 8;

    typedef enum logic [1:0] {
        ROUTE_UNICAST = 2'd0,
        ROUTE_DROP    = 2'd1,
        ROUTE_BCAST   = 2'd2
    } route_e;

    // Saturating increment for a counter of 'width' bits (width < 32).
    function automatic logic [31:0] sat_inc(input logic [31:0] value, input int width);
        logic [31:0] max_val;
        max_val = (32'd1 << width) - 32'd1;
        return (value >= max_val) ? value : value + 32'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/demux_stream_if.sv
`default_nettype none
// ============================================================================
// Module   : demux_stream_if
// Brief    : Producer-side and consumer-side handshake bundle of demux_stream.
// Revision : 1.0 - initial release
// ============================================================================
interface demux_stream_if
    import demux_pkg::*;
#(
    parameter int WIDTH  = c_DEFAULT_WIDTH,
    parameter int NUM_CH = c_DEFAULT_NUM_CH,
    parameter int SEL_W  = c_DEFAULT_SEL_W,
    parameter int CNT_W  = c_DEFAULT_CNT_W
);
    logic                    in_valid;
    logic                    in_ready;
    logic [WIDTH-1:0]        in_data;
    logic [SEL_W-1:0]        in_sel;
    logic                    in_bcast;
    logic [NUM_CH-1:0]       out_valid;
    logic [NUM_CH-1:0]       out_ready;
    logic [NUM_CH*WIDTH-1:0] out_data;
    logic [CNT_W-1:0]        drop_cnt;
    logic                    busy;

    modport master (
        output in_valid, in_data, in_sel, in_bcast, out_ready,
        input  in_ready, out_valid, out_data, drop_cnt, busy
    );

    modport slave (
        input  in_valid, in_data, in_sel, in_bcast, out_ready,
        output in_ready, out_valid, out_data, drop_cnt, busy
    );
endinterface
`default_nettype wire

// File: rtl/demux_slot.sv
`default_nettype none
// ============================================================================
// Module   : demux_slot
// Brief    : One-entry output register for a single demux channel.
// Revision : 1.0 - initial release
// ============================================================================
module demux_slot #(
    parameter int WIDTH = 8
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_load,
    input  wire logic [WIDTH-1:0] i_data,
    input  wire logic             i_ready,
    output logic                  o_valid,
    output logic [WIDTH-1:0]      o_data,
    output logic                  o_free
);
    logic             r_full_q;
    logic             w_full_d;
    logic [WIDTH-1:0] r_data_q;
    logic [WIDTH-1:0] w_data_d;

    always_comb begin
        w_full_d = r_full_q;
        w_data_d = r_data_q;
        // A load wins over a drain so a streaming channel stays full.
        if (i_load) begin
            w_full_d = 1'b1;
            w_data_d = i_data;
        end else if (i_ready) begin
            w_full_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_full_q <= 1'b0;
            r_data_q <= '0;
        end else begin
            r_full_q <= w_full_d;
            r_data_q <= w_data_d;
        end
    end

    assign o_valid = r_full_q;
    assign o_data  = r_data_q;
    assign o_free  = !r_full_q || i_ready;

endmodule
`default_nettype wire

// File: rtl/demux_stream.sv
`default_nettype none
// ============================================================================
// Module   : demux_stream
// Brief    : Registered 1-to-NUM_CH stream demux with broadcast, per-channel
//            handshake and a saturating counter of out-of-range beats.
// Revision : 1.0 - initial release
// ============================================================================
module demux_stream
    import demux_pkg::*;
#(
    parameter int WIDTH  = c_DEFAULT_WIDTH,
    parameter int NUM_CH = c_DEFAULT_NUM_CH,
    parameter int SEL_W  = c_DEFAULT_SEL_W,
    parameter int CNT_W  = c_DEFAULT_CNT_W
) (
    input  wire logic     clk,
    input  wire logic     rst,
    demux_stream_if.slave bus
);
    localparam logic [SEL_W:0] c_NUM_CH = (SEL_W+1)'(NUM_CH);

    logic [NUM_CH-1:0]       w_free;
    logic [NUM_CH-1:0]       w_load;
    logic [NUM_CH-1:0]       w_valid;
    logic [NUM_CH*WIDTH-1:0] w_data;
    route_e                  w_route;
    logic                    w_sel_free;
    logic                    w_ready;
    logic                    w_accept;
    logic [CNT_W-1:0]        r_drop_cnt_q;
    logic [CNT_W-1:0]        w_drop_cnt_d;

    always_comb begin
        w_route = ROUTE_UNICAST;
        if (bus.in_bcast) begin
            w_route = ROUTE_BCAST;
        end else if ({1'b0, bus.in_sel} >= c_NUM_CH) begin
            w_route = ROUTE_DROP;
        end

        // Explicit scan keeps out-of-range selects from indexing past w_free.
        w_sel_free = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (bus.in_sel == SEL_W'(i)) begin
                w_sel_free = w_free[i];
            end
        end

        case (w_route)
            ROUTE_BCAST: w_ready = &w_free;
            ROUTE_DROP:  w_ready = 1'b1;
            default:     w_ready = w_sel_free;
        endcase

        w_accept = bus.in_valid && w_ready;

        w_load = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_load[i] = w_accept && ((w_route == ROUTE_BCAST) ||
                        ((w_route == ROUTE_UNICAST) && (bus.in_sel == SEL_W'(i))));
        end

        w_drop_cnt_d = r_drop_cnt_q;
        if (w_accept && (w_route == ROUTE_DROP)) begin
            w_drop_cnt_d = CNT_W'(sat_inc(32'(r_drop_cnt_q), CNT_W));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_drop_cnt_q <= '0;
        end else begin
            r_drop_cnt_q <= w_drop_cnt_d;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_slot
        demux_slot #(
            .WIDTH (WIDTH)
        ) u_slot (
            .clk     (clk),
            .rst     (rst),
            .i_load  (w_load[i]),
            .i_data  (bus.in_data),
            .i_ready (bus.out_ready[i]),
            .o_valid (w_valid[i]),
            .o_data  (w_data[i*WIDTH +: WIDTH]),
            .o_free  (w_free[i])
        );
    end

    assign bus.in_ready  = w_ready;
    assign bus.out_valid = w_valid;
    assign bus.out_data  = w_data;
    assign bus.drop_cnt  = r_drop_cnt_q;
    assign bus.busy      = |w_valid;

endmodule
`default_nettype wire

// File: tb/tb_demux_stream.sv
`default_nettype none
// ============================================================================
// Module   : tb_demux_stream
// Brief    : Self-checking bench for demux_stream (vector table, corner-case
//            sequences and constrained-random traffic against a slot model).
// Revision : 1.0 - initial release
// ============================================================================
module tb_demux_stream;
    localparam int c_W  = 8;
    localparam int c_N  = 7;
    localparam int c_SW = 3;
    localparam int c_CW = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    demux_stream_if #(.WIDTH(c_W), .NUM_CH(c_N), .SEL_W(c_SW), .CNT_W(c_CW)) bus ();

    demux_stream #(.WIDTH(c_W), .NUM_CH(c_N), .SEL_W(c_SW), .CNT_W(c_CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: one occupancy flag and one data byte per channel.
    bit             m_full [c_N];
    logic [c_W-1:0] m_data [c_N];
    int             m_drop;
    bit             g_held;

    typedef struct {
        logic [c_SW-1:0] sel;
        logic [c_W-1:0]  data;
        logic [c_N-1:0]  exp_valid;
        logic [c_CW-1:0] exp_drop;
    } vec_t;
    vec_t tbl [12];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_free(input int i);
        return !m_full[i] || bus.out_ready[i];
    endfunction

    function automatic bit m_ready();
        bit r;
        if (bus.in_bcast) begin
            r = 1'b1;
            for (int i = 0; i < c_N; i++) r = r && m_free(i);
        end else if (int'(bus.in_sel) < c_N) begin
            r = m_free(int'(bus.in_sel));
        end else begin
            r = 1'b1;
        end
        return r;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < c_N; i++) begin
            m_full[i] = 1'b0;
            m_data[i] = '0;
        end
        m_drop = 0;
    endtask

    task automatic m_clock();
        bit acc;
        acc = bus.in_valid && m_ready();
        for (int i = 0; i < c_N; i++) begin
            if (acc && (bus.in_bcast || int'(bus.in_sel) == i)) begin
                m_full[i] = 1'b1;
                m_data[i] = bus.in_data;
            end else if (bus.out_ready[i]) begin
                m_full[i] = 1'b0;
            end
        end
        if (acc && !bus.in_bcast && int'(bus.in_sel) >= c_N)
            m_drop = (m_drop + 1 > 3) ? 3 : m_drop + 1;
    endtask

    task automatic check_model();
        logic [c_N-1:0] v;
        for (int i = 0; i < c_N; i++) v[i] = m_full[i];
        check("out_valid", 64'(bus.out_valid), 64'(v));
        for (int i = 0; i < c_N; i++)
            if (m_full[i]) check($sformatf("out_data[%0d]", i),
                                 64'(bus.out_data[i*c_W +: c_W]), 64'(m_data[i]));
        check("drop_cnt", 64'(bus.drop_cnt), 64'(m_drop));
        check("busy", 64'(bus.busy), 64'(|v));
    endtask

    // Inputs are set at posedge+1; ready is compared before the edge, outputs after.
    task automatic cycle();
        #1;
        check("in_ready", 64'(bus.in_ready), 64'(m_ready()));
        g_held = bus.in_valid && !m_ready();
        @(posedge clk);
        m_clock();
        #1;
        check_model();
    endtask

    task automatic drive(input bit v, input int sel, input bit bc, input logic [c_W-1:0] d);
        bus.in_valid = v;
        bus.in_sel   = c_SW'(sel);
        bus.in_bcast = bc;
        bus.in_data  = d;
    endtask

    function automatic logic [c_W-1:0] ch(input int i);
        return bus.out_data[i*c_W +: c_W];
    endfunction

    initial begin
        for (int s = 0; s < 7; s++)
            tbl[s] = '{c_SW'(s), 8'hA0 + 8'(s), c_N'(1 << s), 2'd0};
        for (int k = 0; k < 5; k++)
            tbl[7+k] = '{3'd7, 8'hEE, 7'd0, c_CW'((k < 3) ? k + 1 : 3)};

        rst = 1'b1;
        drive(0, 0, 0, 8'h00);
        bus.out_ready = '1;
        m_reset();
        g_held = 1'b0;
        #12;
        check_model();
        check("reset out_data", 64'(bus.out_data), 64'd0);
        check("reset in_ready", 64'(bus.in_ready), 64'd1);
        @(negedge clk) rst = 1'b0;
        @(posedge clk);
        #1;

        // Sweep and out-of-range drops from the vector table.
        foreach (tbl[t]) begin
            drive(1, int'(tbl[t].sel), 0, tbl[t].data);
            #1 check("tbl in_ready", 64'(bus.in_ready), 64'd1);
            cycle();
            check("tbl out_valid", 64'(bus.out_valid), 64'(tbl[t].exp_valid));
            if (tbl[t].exp_valid != 0)
                check("tbl data", 64'(ch(int'(tbl[t].sel))), 64'(tbl[t].data));
            check("tbl drop_cnt", 64'(bus.drop_cnt), 64'(tbl[t].exp_drop));
        end
        drive(0, 0, 0, 8'h00);
        cycle();

        // Backpressure on channel 3.
        bus.out_ready = 7'h77;
        drive(1, 3, 0, 8'h11);
        cycle();
        drive(1, 3, 0, 8'h22);
        #1 check("bp in_ready low", 64'(bus.in_ready), 64'd0);
        cycle();
        cycle();
        check("bp held data", 64'(ch(3)), 64'h11);
        bus.out_ready = '1;
        cycle();
        check("bp second valid", 64'(bus.out_valid), 64'h08);
        check("bp second data", 64'(ch(3)), 64'h22);
        drive(0, 0, 0, 8'h00);
        cycle();
        check("bp drained", 64'(bus.out_valid), 64'h00);

        // Broadcast blocked by a full, stalled channel 6.
        bus.out_ready = 7'h3F;
        drive(1, 6, 0, 8'h66);
        cycle();
        drive(1, 0, 1, 8'h5A);
        #1 check("bc in_ready low", 64'(bus.in_ready), 64'd0);
        cycle();
        bus.out_ready = '1;
        #1 check("bc in_ready high", 64'(bus.in_ready), 64'd1);
        cycle();
        check("bc all valid", 64'(bus.out_valid), 64'h7F);
        for (int i = 0; i < c_N; i++) check("bc data", 64'(ch(i)), 64'h5A);
        drive(0, 0, 0, 8'h00);
        cycle();

        // Streaming 20 beats to channel 1.
        for (int k = 0; k < 20; k++) begin
            drive(1, 1, 0, 8'h30 + 8'(k));
            cycle();
            check("stream valid", 64'(bus.out_valid), 64'h02);
            check("stream data", 64'(ch(1)), 64'(8'h30 + 8'(k)));
        end
        drive(0, 0, 0, 8'h00);
        cycle();

        // Asynchronous reset while channels 0 and 2 hold beats.
        bus.out_ready = '0;
        drive(1, 0, 0, 8'hC0);
        cycle();
        drive(1, 2, 0, 8'hC2);
        cycle();
        drive(0, 0, 0, 8'h00);
        check("pre-reset valid", 64'(bus.out_valid), 64'h05);
        #2 rst = 1'b1;
        #1;
        m_reset();
        check("async rst valid", 64'(bus.out_valid), 64'h00);
        check("async rst data", 64'(bus.out_data), 64'd0);
        check("async rst busy", 64'(bus.busy), 64'd0);
        check("async rst drop", 64'(bus.drop_cnt), 64'd0);
        @(negedge clk) rst = 1'b0;
        bus.out_ready = '1;
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) cycle();

        // Constrained-random traffic; a stalled beat is held unchanged.
        g_held = 1'b0;
        for (int k = 0; k < 400; k++) begin
            if (!g_held)
                drive(($urandom_range(0, 9) < 7), int'($urandom_range(0, 7)),
                      ($urandom_range(0, 7) == 0), c_W'($urandom));
            for (int i = 0; i < c_N; i++)
                bus.out_ready[i] = ($urandom_range(0, 3) != 0);
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
